// File: rtl/hwpe_vfpu_job_programmer.sv
// Bus initiator that programs one VFPU HWPE job: acquire a slot, write the job
// registers, trigger, poll STATUS until idle, then pulse done_o.
module hwpe_vfpu_job_programmer #(
    parameter logic [31:0] CTRL_BASE_ADDR = 32'h0000_0000,
    parameter int          N_JOB_REGS     = 14,
    parameter int          POLL_INTERVAL  = 16,
    parameter int          BACKOFF_CYCLES = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    job_valid_i,
    output logic                    job_ready_o,
    input  logic [32*N_JOB_REGS-1:0] job_desc_i,
    output logic                    req_o,
    input  logic                    gnt_i,
    output logic [31:0]             add_o,
    output logic                    wen_o,
    output logic [3:0]              be_o,
    output logic [31:0]             data_o,
    input  logic [31:0]             r_data_i,
    input  logic                    r_valid_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [7:0]              job_id_o
);

    localparam int CW   = $clog2(N_JOB_REGS) + 1;
    localparam int WMAX = (POLL_INTERVAL > BACKOFF_CYCLES) ? POLL_INTERVAL : BACKOFF_CYCLES;
    localparam int WW   = $clog2(WMAX) + 1;

    localparam logic [31:0] TRIGGER_ADDR = CTRL_BASE_ADDR + 32'h00;
    localparam logic [31:0] ACQUIRE_ADDR = CTRL_BASE_ADDR + 32'h04;
    localparam logic [31:0] STATUS_ADDR  = CTRL_BASE_ADDR + 32'h0C;
    localparam logic [31:0] JOB_BASE     = CTRL_BASE_ADDR + 32'h40;

    localparam logic [CW-1:0] LAST_IDX     = CW'(N_JOB_REGS - 1);
    localparam logic [WW-1:0] BACKOFF_LOAD = WW'(BACKOFF_CYCLES - 1);
    localparam logic [WW-1:0] POLL_LOAD    = WW'(POLL_INTERVAL - 1);

    typedef enum logic [3:0] {
        IDLE,
        ACQ_REQ,
        ACQ_RESP,
        BACKOFF,
        WR_REG,
        TRIGGER,
        POLL_WAIT,
        POLL_REQ,
        POLL_RESP,
        DONE
    } state_t;

    state_t         state_reg;
    logic [CW-1:0]  reg_cnt_reg;
    logic [WW-1:0]  wait_cnt_reg;

    logic [31:0]    desc_words [N_JOB_REGS];
    logic [31:0]    desc_reg   [N_JOB_REGS];
    logic [CW-1:0]  next_idx;
    logic [31:0]    next_word;
    logic [31:0]    next_addr;
    logic           accept;

    genvar gi;
    generate
        for (gi = 0; gi < N_JOB_REGS; gi++) begin : g_unpack
            assign desc_words[gi] = job_desc_i[32*gi +: 32];
        end
    endgenerate

    assign be_o   = 4'hF;
    assign accept = (state_reg == IDLE) && job_valid_i && job_ready_o;

    // Descriptor is captured only on accept, so input changes while busy are invisible.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int i = 0; i < N_JOB_REGS; i++) begin
                desc_reg[i] <= desc_words[i];
            end
        end
    end

    // Address and data for the write after the one being granted, so writes can go back-to-back.
    assign next_idx  = reg_cnt_reg + 1'b1;
    assign next_addr = JOB_BASE + (32'(next_idx) << 2);

    always_comb begin
        next_word = '0;
        for (int i = 0; i < N_JOB_REGS; i++) begin
            if (next_idx == CW'(i)) begin
                next_word = desc_reg[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            req_o        <= 1'b0;
            wen_o        <= 1'b1;
            add_o        <= '0;
            data_o       <= '0;
            job_ready_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            job_id_o     <= '0;
            reg_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    job_ready_o <= 1'b1;
                    if (accept) begin
                        job_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        reg_cnt_reg <= '0;
                        req_o       <= 1'b1;
                        wen_o       <= 1'b1;
                        add_o       <= ACQUIRE_ADDR;
                        state_reg   <= ACQ_REQ;
                    end
                end
                ACQ_REQ: begin
                    if (gnt_i) begin
                        req_o     <= 1'b0;
                        state_reg <= ACQ_RESP;
                    end
                end
                ACQ_RESP: begin
                    if (r_valid_i) begin
                        if (r_data_i[31]) begin
                            wait_cnt_reg <= BACKOFF_LOAD;
                            state_reg    <= BACKOFF;
                        end else begin
                            job_id_o  <= r_data_i[7:0];
                            req_o     <= 1'b1;
                            wen_o     <= 1'b0;
                            add_o     <= JOB_BASE;
                            data_o    <= desc_reg[0];
                            state_reg <= WR_REG;
                        end
                    end
                end
                BACKOFF: begin
                    if (wait_cnt_reg == '0) begin
                        req_o     <= 1'b1;
                        wen_o     <= 1'b1;
                        add_o     <= ACQUIRE_ADDR;
                        state_reg <= ACQ_REQ;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end
                WR_REG: begin
                    if (gnt_i) begin
                        reg_cnt_reg <= next_idx;
                        if (reg_cnt_reg == LAST_IDX) begin
                            add_o     <= TRIGGER_ADDR;
                            data_o    <= '0;
                            state_reg <= TRIGGER;
                        end else begin
                            add_o  <= next_addr;
                            data_o <= next_word;
                        end
                    end
                end
                TRIGGER: begin
                    if (gnt_i) begin
                        req_o        <= 1'b0;
                        wen_o        <= 1'b1;
                        wait_cnt_reg <= POLL_LOAD;
                        state_reg    <= POLL_WAIT;
                    end
                end
                POLL_WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        req_o     <= 1'b1;
                        wen_o     <= 1'b1;
                        add_o     <= STATUS_ADDR;
                        state_reg <= POLL_REQ;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end
                POLL_REQ: begin
                    if (gnt_i) begin
                        req_o     <= 1'b0;
                        state_reg <= POLL_RESP;
                    end
                end
                POLL_RESP: begin
                    if (r_valid_i) begin
                        if (r_data_i == '0) begin
                            done_o    <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            wait_cnt_reg <= POLL_LOAD;
                            state_reg    <= POLL_WAIT;
                        end
                    end
                end
                DONE: begin
                    busy_o      <= 1'b0;
                    job_ready_o <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hwpe_vfpu_job_programmer.sv
// Randomized bench for hwpe_vfpu_job_programmer: a bus slave model answers reads,
// a scoreboard holds the expected bus transfers and job ids per job.
module tb_hwpe_vfpu_job_programmer;

    localparam int          N    = 14;
    localparam int          P    = 16;
    localparam int          B    = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] TRIG = BASE + 32'h00;
    localparam logic [31:0] ACQ  = BASE + 32'h04;
    localparam logic [31:0] STAT = BASE + 32'h0C;

    logic            clk;
    logic            rst_i;
    logic            job_valid_i;
    logic            job_ready_o;
    logic [32*N-1:0] job_desc_i;
    logic            req_o;
    logic            gnt_i;
    logic [31:0]     add_o;
    logic            wen_o;
    logic [3:0]      be_o;
    logic [31:0]     data_o;
    logic [31:0]     r_data_i;
    logic            r_valid_i;
    logic            busy_o;
    logic            done_o;
    logic [7:0]      job_id_o;

    hwpe_vfpu_job_programmer #(
        .CTRL_BASE_ADDR(BASE),
        .N_JOB_REGS    (N),
        .POLL_INTERVAL (P),
        .BACKOFF_CYCLES(B)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .job_valid_i(job_valid_i),
        .job_ready_o(job_ready_o),
        .job_desc_i (job_desc_i),
        .req_o      (req_o),
        .gnt_i      (gnt_i),
        .add_o      (add_o),
        .wen_o      (wen_o),
        .be_o       (be_o),
        .data_o     (data_o),
        .r_data_i   (r_data_i),
        .r_valid_i  (r_valid_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .job_id_o   (job_id_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] add;
        logic [31:0] data;
        int          gap;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [31:0] acq_q[$];
    logic [31:0] stat_q[$];
    logic [7:0]  exp_id_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cycle = 0;
    int accept_cnt = 0;
    int done_cnt = 0;
    int done_target = 0;
    int accept_cyc = 0;
    int last_xfer_cyc = 0;
    int stall_run = 0;
    int pend_cnt = 0;
    bit pend_active = 0;
    logic [31:0] pend_data = '0;
    bit stall_en = 0;
    bit lat_fixed = 1;
    bit lat_chk = 0;
    bit inflight = 0;
    bit prev_stall = 0;
    bit prev_done = 0;
    logic [31:0] prev_add, prev_data;
    logic prev_wen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Bus slave: grants (optionally stalled up to 4 cycles) and delayed read data.
    initial begin
        gnt_i = 1'b0;
        r_valid_i = 1'b0;
        r_data_i = '0;
    end

    always @(posedge clk) begin
        cycle++;
        #1;
        r_valid_i = 1'b0;
        r_data_i  = $urandom;
        if (pend_active) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                r_valid_i   = 1'b1;
                r_data_i    = pend_data;
                pend_active = 0;
            end
        end
        if (!stall_en || stall_run >= 4 || $urandom_range(0, 2) == 0) begin
            gnt_i = 1'b1;
            stall_run = 0;
        end else begin
            gnt_i = 1'b0;
            stall_run++;
        end
    end

    // Monitor / scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst_i) begin
            prev_stall = 0;
            prev_done  = 0;
        end else begin
            if (prev_stall) begin
                chk("req_held", {31'b0, req_o}, 32'd1);
                chk("add_stable", add_o, prev_add);
                chk("data_stable", data_o, prev_data);
                chk("wen_stable", {31'b0, wen_o}, {31'b0, prev_wen});
            end
            if (prev_done) chk("done_pulse", {31'b0, done_o}, 32'd0);
            if (job_valid_i && job_ready_o) begin
                chk("accept_idle", {31'b0, inflight}, 32'd0);
                inflight   = 1;
                accept_cnt++;
                accept_cyc = cycle;
                $display("accept job #%0d at cycle %0d", accept_cnt, cycle);
            end
            if (req_o && gnt_i) begin
                chk("be", {28'b0, be_o}, 32'hF);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got add=%0h wen=%0b, required none", add_o, wen_o);
                end else begin
                    xfer_t e;
                    e = exp_q.pop_front();
                    $display("xfer %s add=%0h data=%0h cycle=%0d", wen_o ? "RD" : "WR", add_o, data_o, cycle);
                    chk("xfer_wen", {31'b0, wen_o}, {31'b0, e.wen});
                    chk("xfer_add", add_o, e.add);
                    if (!e.wen) chk("xfer_data", data_o, e.data);
                    if (e.gap > 0)
                        chk("xfer_gap", ((cycle - last_xfer_cyc) >= e.gap) ? 32'd1 : 32'd0, 32'd1);
                end
                if (wen_o) begin
                    pend_active = 1;
                    pend_cnt    = lat_fixed ? 1 : int'($urandom_range(1, 3));
                    if (add_o == ACQ) pend_data = (acq_q.size() > 0) ? acq_q.pop_front() : 32'h0;
                    else              pend_data = (stat_q.size() > 0) ? stat_q.pop_front() : 32'h0;
                end
                if (lat_chk && !wen_o && add_o == TRIG)
                    chk("trigger_latency", 32'(cycle - accept_cyc), 32'(N + 3));
                last_xfer_cyc = cycle;
            end
            if (done_o) begin
                if (exp_id_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done_o=1, required 0");
                end else begin
                    chk("job_id", {24'b0, job_id_o}, {24'b0, exp_id_q.pop_front()});
                end
                chk("busy_at_done", {31'b0, busy_o}, 32'd1);
                $display("done job_id=%0d at cycle %0d", job_id_o, cycle);
                inflight = 0;
                done_cnt++;
            end
            prev_stall = req_o && !gnt_i;
            prev_add   = add_o;
            prev_data  = data_o;
            prev_wen   = wen_o;
            prev_done  = done_o;
        end
    end

    task automatic push_x(input logic wen, input logic [31:0] add, input logic [31:0] data, input int gap);
        xfer_t x;
        x.wen = wen; x.add = add; x.data = data; x.gap = gap;
        exp_q.push_back(x);
    endtask

    // Reference model: the full bus sequence one job must produce.
    task automatic prepare_job(input int n_ref, input logic [7:0] id, input int n_busy,
                               output logic [32*N-1:0] d);
        logic [31:0] w;
        for (int r = 0; r < n_ref; r++) begin
            push_x(1'b1, ACQ, 32'h0, (r == 0) ? 0 : B + 1);
            acq_q.push_back((r == 0) ? 32'hFFFF_FFFF : ($urandom | 32'h8000_0000));
        end
        push_x(1'b1, ACQ, 32'h0, (n_ref > 0) ? B + 1 : 0);
        w = $urandom;
        acq_q.push_back({1'b0, w[22:0], id});
        for (int k = 0; k < N; k++) begin
            w = $urandom;
            d[32*k +: 32] = w;
            push_x(1'b0, BASE + 32'h40 + 32'(4 * k), w, 0);
        end
        push_x(1'b0, TRIG, 32'h0, 0);
        for (int p = 0; p <= n_busy; p++) begin
            push_x(1'b1, STAT, 32'h0, P + 1);
            stat_q.push_back((p < n_busy) ? ($urandom | 32'h1) : 32'h0);
        end
        exp_id_q.push_back(id);
        done_target++;
    endtask

    task automatic wait_accept(input int target);
        int t;
        for (t = 0; t < 3000 && accept_cnt < target; t++) @(posedge clk);
        #1;
        if (accept_cnt < target) chk("accept_timeout", 32'(accept_cnt), 32'(target));
    endtask

    task automatic start_job(input logic [32*N-1:0] d);
        job_desc_i  = d;
        job_valid_i = 1'b1;
        wait_accept(accept_cnt + 1);
        job_valid_i = 1'b0;
        for (int k = 0; k < N; k++) job_desc_i[32*k +: 32] = $urandom;
    endtask

    task automatic wait_done();
        int t;
        for (t = 0; t < 5000 && done_cnt < done_target; t++) @(posedge clk);
        #1;
        if (done_cnt < done_target) chk("done_timeout", 32'(done_cnt), 32'(done_target));
    endtask

    initial begin
        logic [32*N-1:0] d1, d2;
        int t;
        rst_i = 1'b1;
        job_valid_i = 1'b0;
        job_desc_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, req_o}, 32'd0);
        chk("rst_wen", {31'b0, wen_o}, 32'd1);
        chk("rst_add", add_o, 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_be", {28'b0, be_o}, 32'hF);
        chk("rst_ready", {31'b0, job_ready_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_id", {24'b0, job_id_o}, 32'd0);
        rst_i = 1'b0;

        // Immediate grants, fixed one-cycle read latency, latency check on.
        lat_chk = 1;
        prepare_job(0, 8'd3, 0, d1);
        start_job(d1);
        wait_done();
        lat_chk = 0;

        // Two refused acquires, random read latency.
        lat_fixed = 0;
        prepare_job(2, 8'd5, 0, d1);
        start_job(d1);
        wait_done();

        // Random grant stalls.
        stall_en = 1;
        for (int j = 0; j < 3; j++) begin
            prepare_job(int'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 2)), d1);
            start_job(d1);
            wait_done();
        end
        stall_en = 0;

        // STATUS busy four times.
        prepare_job(0, 8'($urandom), 4, d1);
        start_job(d1);
        wait_done();

        // Reset in the middle of the register writes.
        prepare_job(0, 8'($urandom), 0, d1);
        start_job(d1);
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (req_o && !wen_o && add_o == BASE + 32'h58) break;
        end
        if (t == 200) chk("reach_k6", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_req", {31'b0, req_o}, 32'd0);
        chk("midrst_busy", {31'b0, busy_o}, 32'd0);
        exp_q.delete();
        acq_q.delete();
        stat_q.delete();
        exp_id_q.delete();
        pend_active = 0;
        inflight = 0;
        done_target = done_cnt;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ready", {31'b0, job_ready_o}, 32'd1);
        prepare_job(0, 8'($urandom), 1, d1);
        start_job(d1);
        wait_done();

        // job_valid_i held high across two jobs; descriptor changes while busy.
        prepare_job(0, 8'($urandom), 0, d1);
        prepare_job(1, 8'($urandom), 1, d2);
        job_desc_i  = d1;
        job_valid_i = 1'b1;
        wait_accept(accept_cnt + 1);
        job_desc_i  = d2;
        wait_accept(accept_cnt + 1);
        job_valid_i = 1'b0;
        wait_done();

        repeat (5) @(posedge clk);
        #1;
        chk("exp_empty", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(done_target));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
